touch_keys_deb: RTL and testbench
=================================

Name: touch_keys_deb

Overview:
- Parametrised successor to the fixed 3-key touch-zone decoder. Maps touch coordinates onto NUM_KEYS rectangular keys laid out in one row.
- Debounces press and release over consecutive qualified samples.
- Emits a debounced level, one-clock press/release pulses and the index of the held key.
- Sits between the touch-controller coordinate path and the UI/menu control logic.

Parameters:
- NUM_KEYS, 3, number of keys in the row (1..8)
- X_W, 10, width of tor_x
- Y_W, 9, width of tor_y
- KEY_X0, 60, left edge of key 0 (inclusive)
- KEY_W, 78, key width; key k spans x = KEY_X0+k*KEY_PITCH .. +KEY_W, both edges inclusive
- KEY_PITCH, 200, x distance between left edges of adjacent keys (must exceed KEY_W)
- KEY_Y_LO, 149, top edge, inclusive
- KEY_Y_HI, 228, bottom edge, inclusive
- SAMPLE_PHASE, 1, clcount value on which a sample qualifies
- DEB_SAMPLES, 3, consecutive same-key samples needed to declare a press (>=1)
- REL_SAMPLES, 3, consecutive non-key samples needed to declare a release (>=1)

Ports:
- clk, in, 1, system clock
- reset, in, 1, asynchronous, active-low reset
- clcount, in, 2, touch-scan phase counter
- enable, in, 1, coordinate-valid gate
- tor_x, in, X_W, touch x coordinate
- tor_y, in, Y_W, touch y coordinate
- key_level, out, NUM_KEYS, one-hot debounced held state
- key_press, out, NUM_KEYS, one-clock press pulse
- key_release, out, NUM_KEYS, one-clock release pulse
- key_idx, out, clog2(NUM_KEYS) (min 1), index of held/armed key
- key_busy, out, 1, high when the FSM is not IDLE

Behaviour:
- Qualified sample: enable==1 && clcount==SAMPLE_PHASE. Non-qualified cycles freeze the FSM, counter, key_idx and key_level. key_press and key_release are 0 on non-qualified cycles.
- Hit decode (combinational): hit = 1 with hit_idx = k if (tor_x, tor_y) lies inside key k's rectangle, edges inclusive. Arithmetic uses X_W+4 bits so edge computations do not overflow. Keys never overlap, so at most one k matches.
- FSM states: IDLE, ARM, HELD, REL. The counter is clog2(max(DEB_SAMPLES,REL_SAMPLES)+1) bits wide.
- IDLE + hit:
  - DEB_SAMPLES==1: go directly to HELD and issue the press pulse.
  - Otherwise: go to ARM with cnt=1, key_idx=hit_idx.
- ARM:
  - hit on the same key: cnt+1. When cnt reaches DEB_SAMPLES, go to HELD, set key_level[key_idx], pulse key_press[key_idx].
  - hit on a different key: stay in ARM, cnt=1, key_idx=new key.
  - no hit: go to IDLE, cnt=0.
- HELD:
  - hit on the held key: stay.
  - any other sample (no hit or a different key): REL_SAMPLES==1 releases immediately; otherwise go to REL with cnt=1.
- REL:
  - hit on the held key: back to HELD, cnt=0, no pulses.
  - otherwise cnt+1. When cnt reaches REL_SAMPLES, go to IDLE, clear key_level, pulse key_release[key_idx].
  - A different key cannot press until the FSM has returned to IDLE and re-armed.
- Latency: a pulse is registered and appears on the clock edge that closes the qualifying sample cycle. It is high for exactly one clk.
- key_level is at most one-hot and stays high from the press pulse until the release pulse.
- key_press and key_release are never asserted in the same cycle.
- Reset (async assert, sync deassert upstream): state=IDLE and cnt=0. All outputs 0. Reset asserted while HELD produces no release pulse.

Optional Feature:
- Macro: TOUCH_KEYS_AUTOREPEAT_EN. Adds parameters REPEAT_DELAY (default 16) and REPEAT_PERIOD (default 4), both counted in qualified samples.
- Defined: an independent repeat counter runs while in HELD.
  - The first extra key_press pulse comes REPEAT_DELAY samples after the press.
  - After that, one pulse every REPEAT_PERIOD samples.
  - The repeat counter pauses in REL, resumes if the FSM returns to HELD, and clears on entry to IDLE.
- Undefined: exactly one key_press pulse per press, and no repeat logic is synthesised.

Test Plan (default parameters):
1. Clean press: 3 qualified samples at (100,180), then 3 at (0,0) -> key_press=3'b001 pulse after the 3rd hit sample and key_level=001; key_release=001 pulse after the 3rd miss, then key_level=000.
2. Edges: (260,149), (338,228), (339,180), (259,180), (300,148), (300,229) each held for 3 samples -> key 1 pressed for the first two; no press for the last four.
3. Bounce: key-2 samples at (500,200) in the pattern hit,hit,miss,hit,hit,hit -> exactly one key_press=100, asserted on the 6th sample; release-side pattern miss,hit,miss,miss,miss -> exactly one key_release, on the last miss.
4. Slide: while HELD on key 0, 3 samples on key 1 -> release of key 0; key 1 press only after 3 further key-1 samples starting from IDLE.
5. Gating: hits with clcount=0/2/3, or with enable=0 -> no state change. Reset pulled low while HELD -> all outputs 0 immediately, no key_release pulse.
6. With TOUCH_KEYS_AUTOREPEAT_EN: hold key 1 for 30 samples -> key_press pulses at samples 3, 19, 23, 27.

Source files
------------

// File: rtl/touch_keys_deb.sv
// rtl/touch_keys_deb.sv - row of NUM_KEYS touch keys with press/release debounce; optional auto-repeat via TOUCH_KEYS_AUTOREPEAT_EN
module touch_keys_deb #(
  parameter int NUM_KEYS     = 3,
  parameter int X_W          = 10,
  parameter int Y_W          = 9,
  parameter int KEY_X0       = 60,
  parameter int KEY_W        = 78,
  parameter int KEY_PITCH    = 200,
  parameter int KEY_Y_LO     = 149,
  parameter int KEY_Y_HI     = 228,
  parameter int SAMPLE_PHASE = 1,
  parameter int DEB_SAMPLES  = 3,
  parameter int REL_SAMPLES  = 3
`ifdef TOUCH_KEYS_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY  = 16,
  parameter int REPEAT_PERIOD = 4
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           clcount,
  input  logic                 enable,
  input  logic [X_W-1:0]       tor_x,
  input  logic [Y_W-1:0]       tor_y,
  output logic [NUM_KEYS-1:0]  key_level,
  output logic [NUM_KEYS-1:0]  key_press,
  output logic [NUM_KEYS-1:0]  key_release,
  output logic [(NUM_KEYS > 1 ? $clog2(NUM_KEYS) : 1)-1:0] key_idx,
  output logic                 key_busy
);

  localparam int IDX_W   = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int XE_W    = X_W + 4;
  localparam int CNT_MAX = (DEB_SAMPLES > REL_SAMPLES) ? DEB_SAMPLES : REL_SAMPLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [Y_W-1:0] Y_LO = Y_W'(KEY_Y_LO);
  localparam logic [Y_W-1:0] Y_HI = Y_W'(KEY_Y_HI);

  typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_HELD, ST_REL} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [NUM_KEYS-1:0]  level_q, level_d;
  logic [NUM_KEYS-1:0]  press_q, press_d, press_base;
  logic [NUM_KEYS-1:0]  rel_q, rel_d;

  logic                 qual, hit, same;
  logic [NUM_KEYS-1:0]  hit_vec;
  logic [IDX_W-1:0]     hit_idx;
  logic [XE_W-1:0]      x_ext, left_e, right_e;
  logic                 rpt_pulse;

  // Map the coordinate onto at most one key rectangle (edges inclusive).
  always_comb begin
    hit_vec = '0;
    hit_idx = '0;
    x_ext   = {4'b0000, tor_x};
    left_e  = '0;
    right_e = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      left_e  = XE_W'(KEY_X0 + k * KEY_PITCH);
      right_e = left_e + XE_W'(KEY_W);
      if (x_ext >= left_e && x_ext <= right_e && tor_y >= Y_LO && tor_y <= Y_HI) begin
        hit_vec[k] = 1'b1;
        hit_idx    = IDX_W'(k);
      end
    end
  end

  assign hit     = |hit_vec;
  assign qual    = enable && (clcount == 2'(SAMPLE_PHASE));
  assign same    = hit && (hit_idx == idx_q);
  assign cnt_inc = cnt_q + 1'b1;

  // Debounce FSM next state; unqualified cycles hold everything and drop pulses.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    level_d    = level_q;
    press_base = '0;
    rel_d      = '0;
    if (qual) begin
      case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (hit) begin
            idx_d = hit_idx;
            if (DEB_SAMPLES == 1) begin
              state_d    = ST_HELD;
              level_d    = hit_vec;
              press_base = hit_vec;
            end else begin
              state_d = ST_ARM;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        ST_ARM: begin
          if (same) begin
            if (cnt_inc == CNT_W'(DEB_SAMPLES)) begin
              state_d    = ST_HELD;
              cnt_d      = '0;
              level_d    = hit_vec;
              press_base = hit_vec;
            end else begin
              cnt_d = cnt_inc;
            end
          end else if (hit) begin
            cnt_d = CNT_W'(1);
            idx_d = hit_idx;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
        ST_HELD: begin
          if (!same) begin
            if (REL_SAMPLES == 1) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
              level_d = '0;
              rel_d   = level_q;
            end else begin
              state_d = ST_REL;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        ST_REL: begin
          if (same) begin
            state_d = ST_HELD;
            cnt_d   = '0;
          end else if (cnt_inc == CNT_W'(REL_SAMPLES)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            level_d = '0;
            rel_d   = level_q;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

`ifdef TOUCH_KEYS_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] rpt_q, rpt_d, rpt_inc, rpt_target;
  logic             first_q, first_d;

  assign rpt_inc    = rpt_q + 1'b1;
  assign rpt_target = first_q ? RPT_W'(REPEAT_DELAY) : RPT_W'(REPEAT_PERIOD);

  // Repeat counter: restarts on press, pauses outside HELD, clears when going idle.
  always_comb begin
    rpt_d     = rpt_q;
    first_d   = first_q;
    rpt_pulse = 1'b0;
    if ((|rel_d) || (|press_base)) begin
      rpt_d   = '0;
      first_d = 1'b1;
    end else if (qual && state_q == ST_HELD && same) begin
      if (rpt_inc == rpt_target) begin
        rpt_pulse = 1'b1;
        rpt_d     = '0;
        first_d   = 1'b0;
      end else begin
        rpt_d = rpt_inc;
      end
    end
  end

  // Repeat counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rpt_q   <= '0;
      first_q <= 1'b1;
    end else begin
      rpt_q   <= rpt_d;
      first_q <= first_d;
    end
  end
`else
  assign rpt_pulse = 1'b0;
`endif

  assign press_d = press_base | (rpt_pulse ? level_q : '0);

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      level_q <= '0;
      press_q <= '0;
      rel_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = rel_q;
  assign key_idx     = idx_q;
  assign key_busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_touch_keys_deb.sv
// tb/tb_touch_keys_deb.sv - directed bench for touch_keys_deb; covers TOUCH_KEYS_AUTOREPEAT_EN when defined
module tb_touch_keys_deb;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] clcount;
  logic       enable;
  logic [9:0] tor_x;
  logic [8:0] tor_y;
  logic [2:0] key_level, key_press, key_release;
  logic [1:0] key_idx;
  logic       key_busy;

  int n_vec = 0;
  int n_bad = 0;

  touch_keys_deb dut (
    .clk        (clk),
    .reset      (reset),
    .clcount    (clcount),
    .enable     (enable),
    .tor_x      (tor_x),
    .tor_y      (tor_y),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_idx    (key_idx),
    .key_busy   (key_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One qualified sample, then one unqualified gap cycle that must carry no pulse.
  task automatic smp(input int x, input int y, input logic [2:0] ep, input logic [2:0] er,
                     input logic [2:0] el, input string tag);
    @(negedge clk);
    tor_x = 10'(x); tor_y = 9'(y); enable = 1'b1; clcount = 2'd1;
    @(posedge clk); #1;
    chk({tag, ".press"}, key_press, ep);
    chk({tag, ".release"}, key_release, er);
    chk({tag, ".level"}, key_level, el);
    @(negedge clk);
    clcount = 2'd2;
    @(posedge clk); #1;
    chk({tag, ".gap"}, {key_press, key_release}, 6'b0);
  endtask

  // One unqualified cycle: no pulses, level unchanged.
  task automatic nq(input int x, input int y, input logic [1:0] cc, input logic en,
                    input logic [2:0] el, input string tag);
    @(negedge clk);
    tor_x = 10'(x); tor_y = 9'(y); enable = en; clcount = cc;
    @(posedge clk); #1;
    chk({tag, ".pulses"}, {key_press, key_release}, 6'b0);
    chk({tag, ".level"}, key_level, el);
  endtask

  initial begin
    reset = 1'b0; clcount = 2'd0; enable = 1'b0; tor_x = '0; tor_y = '0;
    #1;
    chk("rst.level", key_level, 3'b000);
    chk("rst.press", key_press, 3'b000);
    chk("rst.release", key_release, 3'b000);
    chk("rst.idx", key_idx, 2'd0);
    chk("rst.busy", key_busy, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Clean press and release on key 0
    smp(100, 180, 3'b000, 3'b000, 3'b000, "t1.h1");
    chk("t1.busy_arm", key_busy, 1'b1);
    smp(100, 180, 3'b000, 3'b000, 3'b000, "t1.h2");
    smp(100, 180, 3'b001, 3'b000, 3'b001, "t1.h3");
    chk("t1.idx", key_idx, 2'd0);
    smp(0, 0, 3'b000, 3'b000, 3'b001, "t1.m1");
    smp(0, 0, 3'b000, 3'b000, 3'b001, "t1.m2");
    smp(0, 0, 3'b000, 3'b001, 3'b000, "t1.m3");
    chk("t1.busy_idle", key_busy, 1'b0);

    // Edge coordinates: two inclusive corners of key 1 press
    smp(260, 149, 3'b000, 3'b000, 3'b000, "t2a.1");
    smp(260, 149, 3'b000, 3'b000, 3'b000, "t2a.2");
    smp(260, 149, 3'b010, 3'b000, 3'b010, "t2a.3");
    chk("t2a.idx", key_idx, 2'd1);
    for (int i = 0; i < 3; i++) smp(0, 0, 3'b000, (i == 2) ? 3'b010 : 3'b000, (i == 2) ? 3'b000 : 3'b010, "t2a.rel");
    smp(338, 228, 3'b000, 3'b000, 3'b000, "t2b.1");
    smp(338, 228, 3'b000, 3'b000, 3'b000, "t2b.2");
    smp(338, 228, 3'b010, 3'b000, 3'b010, "t2b.3");
    for (int i = 0; i < 3; i++) smp(0, 0, 3'b000, (i == 2) ? 3'b010 : 3'b000, (i == 2) ? 3'b000 : 3'b010, "t2b.rel");
    // Just outside each edge: never a press
    for (int i = 0; i < 3; i++) smp(339, 180, 3'b000, 3'b000, 3'b000, "t2c.right");
    for (int i = 0; i < 3; i++) smp(259, 180, 3'b000, 3'b000, 3'b000, "t2d.left");
    for (int i = 0; i < 3; i++) smp(300, 148, 3'b000, 3'b000, 3'b000, "t2e.top");
    for (int i = 0; i < 3; i++) smp(300, 229, 3'b000, 3'b000, 3'b000, "t2f.bottom");
    chk("t2.busy", key_busy, 1'b0);

    // Bounce on key 2: hit,hit,miss,hit,hit,hit
    smp(500, 200, 3'b000, 3'b000, 3'b000, "t3.p1");
    smp(500, 200, 3'b000, 3'b000, 3'b000, "t3.p2");
    smp(0, 0, 3'b000, 3'b000, 3'b000, "t3.p3");
    chk("t3.busy_back_idle", key_busy, 1'b0);
    smp(500, 200, 3'b000, 3'b000, 3'b000, "t3.p4");
    smp(500, 200, 3'b000, 3'b000, 3'b000, "t3.p5");
    smp(500, 200, 3'b100, 3'b000, 3'b100, "t3.p6");
    chk("t3.idx", key_idx, 2'd2);
    // Release side: miss,hit,miss,miss,miss
    smp(0, 0, 3'b000, 3'b000, 3'b100, "t3.r1");
    smp(500, 200, 3'b000, 3'b000, 3'b100, "t3.r2");
    smp(0, 0, 3'b000, 3'b000, 3'b100, "t3.r3");
    smp(0, 0, 3'b000, 3'b000, 3'b100, "t3.r4");
    smp(0, 0, 3'b000, 3'b100, 3'b000, "t3.r5");

    // Slide from key 0 to key 1
    for (int i = 0; i < 3; i++) smp(100, 180, (i == 2) ? 3'b001 : 3'b000, 3'b000, (i == 2) ? 3'b001 : 3'b000, "t4.k0");
    smp(300, 180, 3'b000, 3'b000, 3'b001, "t4.s1");
    smp(300, 180, 3'b000, 3'b000, 3'b001, "t4.s2");
    smp(300, 180, 3'b000, 3'b001, 3'b000, "t4.s3");
    smp(300, 180, 3'b000, 3'b000, 3'b000, "t4.s4");
    chk("t4.idx_armed", key_idx, 2'd1);
    smp(300, 180, 3'b000, 3'b000, 3'b000, "t4.s5");
    smp(300, 180, 3'b010, 3'b000, 3'b010, "t4.s6");
    for (int i = 0; i < 3; i++) smp(0, 0, 3'b000, (i == 2) ? 3'b010 : 3'b000, (i == 2) ? 3'b000 : 3'b010, "t4.rel");

    // Gating: hits on the wrong phase or with enable low do nothing
    nq(300, 180, 2'd0, 1'b1, 3'b000, "t5.cc0");
    nq(300, 180, 2'd2, 1'b1, 3'b000, "t5.cc2");
    nq(300, 180, 2'd3, 1'b1, 3'b000, "t5.cc3");
    nq(300, 180, 2'd1, 1'b0, 3'b000, "t5.en0");
    chk("t5.busy_idle", key_busy, 1'b0);
    smp(300, 180, 3'b000, 3'b000, 3'b000, "t5.h1");
    smp(300, 180, 3'b000, 3'b000, 3'b000, "t5.h2");
    nq(0, 0, 2'd3, 1'b1, 3'b000, "t5.freeze_miss");
    nq(300, 180, 2'd1, 1'b0, 3'b000, "t5.freeze_en0");
    chk("t5.busy_arm", key_busy, 1'b1);
    smp(300, 180, 3'b010, 3'b000, 3'b010, "t5.h3");
    nq(0, 0, 2'd0, 1'b1, 3'b010, "t5.held_cc0");
    nq(0, 0, 2'd1, 1'b0, 3'b010, "t5.held_en0");
    chk("t5.idx_held", key_idx, 2'd1);
    // Asynchronous reset while held
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("t5.rst.level", key_level, 3'b000);
    chk("t5.rst.press", key_press, 3'b000);
    chk("t5.rst.release", key_release, 3'b000);
    chk("t5.rst.idx", key_idx, 2'd0);
    chk("t5.rst.busy", key_busy, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) smp(0, 0, 3'b000, 3'b000, 3'b000, "t5.after_rst");

`ifdef TOUCH_KEYS_AUTOREPEAT_EN
    // Auto-repeat: press on sample 3, then 19, 23, 27
    for (int i = 1; i <= 30; i++)
      smp(300, 180, (i == 3 || i == 19 || i == 23 || i == 27) ? 3'b010 : 3'b000, 3'b000,
          (i >= 3) ? 3'b010 : 3'b000, "t6.hold");
    for (int i = 0; i < 3; i++) smp(0, 0, 3'b000, (i == 2) ? 3'b010 : 3'b000, (i == 2) ? 3'b000 : 3'b010, "t6.rel");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
